fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register of the five-stage core. Holds the PC, drives instruction memory, predicts BEQ direction with a 2-bit branch history table (BHT), and registers the fetched instruction for decode. Sits directly upstream of the hazard unit. It supplies ARS1_IF_ID/ARS2_IF_ID and consumes STALL and PCWRITE, which acts as the mispredict redirect.

## Interface
- XLEN, 32, data/address width
- BHT_ENTRIES, 16, predictor entries, power of two ≥ 2
- RESET_PC, 32'h0000_0000, PC value after reset
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- STALL  in  1  hold PC and IF/ID (load-use hazard)
- PCWRITE  in  1  BEQ mispredict: redirect PC and flush IF/ID
- REDIRECT_PC  in  XLEN  corrected PC, valid with PCWRITE
- BEQ_RESOLVE  in  1  a BEQ resolved in EX this cycle
- BEQ_RESOLVE_PC  in  XLEN  PC of the resolved BEQ
- BEQ_TAKEN  in  1  actual outcome of the resolved BEQ
- IMEM_ADDR  out  XLEN  instruction memory address (= PC)
- IMEM_DATA  in  32  instruction word, combinational read of IMEM_ADDR
- PC_IF_ID  out  XLEN  PC of the instruction in IF/ID
- INSTR_IF_ID  out  32  instruction in IF/ID
- PRED_TAKEN_IF_ID  out  1  prediction made for that instruction
- VALID_IF_ID  out  1  IF/ID holds a real instruction
- ARS1_IF_ID  out  5  INSTR_IF_ID[19:15]
- ARS2_IF_ID  out  5  INSTR_IF_ID[24:20]

## Operation
- IMEM_ADDR = PC, combinational from the PC register.
- A fetched word is a BEQ when opcode = 7'b1100011 and funct3 = 3'b000.
- BHT index = PC[$clog2(BHT_ENTRIES)+1:2]. Predict taken when the counter is ≥ 2'b10.
- Next PC:
  - predicted-taken BEQ: PC + sign-extended B-immediate {imm[12:1],0};
  - otherwise: PC + 4.
  - All PC arithmetic wraps modulo 2^XLEN.
- Per-edge priority is reset > PCWRITE > STALL > advance.
  - PCWRITE: PC ← REDIRECT_PC. IF/ID flushes: INSTR_IF_ID ← NOP 32'h0000_0013, VALID_IF_ID ← 0, PRED_TAKEN_IF_ID ← 0, PC_IF_ID ← 0. PCWRITE overrides a simultaneous STALL.
  - STALL (without PCWRITE): PC and all IF/ID outputs hold their values.
  - Advance: PC ← next PC. IF/ID ← {PC, IMEM_DATA, prediction, VALID_IF_ID = 1}.
- BHT update is independent of STALL and PCWRITE.
  - On BEQ_RESOLVE, the entry indexed by BEQ_RESOLVE_PC saturating-increments when BEQ_TAKEN = 1 and saturating-decrements when BEQ_TAKEN = 0.
  - Counters saturate at 2'b11 and 2'b00.
- When a lookup and an update hit the same entry in the same cycle, the lookup uses the pre-update value (write-at-edge).
- ARS1_IF_ID and ARS2_IF_ID are bit slices of INSTR_IF_ID, so both read 0 after a flush or reset.

## Timing
- Reset (asynchronous, RST_N low):
  - PC = RESET_PC;
  - INSTR_IF_ID = 32'h0000_0013, PC_IF_ID = 0, VALID_IF_ID = 0, PRED_TAKEN_IF_ID = 0, ARS1/ARS2 = 0;
  - all BHT counters = 2'b01 (weakly not taken).
- The first real instruction appears in IF/ID one edge after RST_N deasserts.
- Fetch-to-IF/ID latency is 1 cycle. A predicted-taken BEQ costs no bubble.
- Mispredict costs 1 bubble: the edge with PCWRITE loads REDIRECT_PC and a NOP into IF/ID. The corrected instruction reaches IF/ID on the following edge.
- STALL asserted for N cycles holds IF/ID for N cycles. IMEM_ADDR stays constant throughout.
- Reset asserted mid-stall or mid-redirect takes effect immediately, with no dependence on the clock.

## Structure
- The shared core package `core_pkg` holds:
  - NOP constant 32'h0000_0013;
  - OPC_BRANCH 7'b1100011 and F3_BEQ 3'b000;
  - typedef `bht_ctr_t` (logic [1:0]) with constants SNT/WNT/WT/ST.
- Sub-module `bht_predictor` (parameter BHT_ENTRIES):
  - lookup port: index → predict;
  - update port: valid, index, taken;
  - asynchronous active-low reset to WNT.
- The PC register, next-PC mux, and IF/ID register stay in `fetch_stage`.

## Test plan
- Reset with RESET_PC = 0, then release with no stall and non-branch words → IMEM_ADDR steps 0, 4, 8. PC_IF_ID lags by one cycle with VALID_IF_ID = 1.
- IMEM_DATA = 32'h00208463 (BEQ x1,x2,+8) at PC 0x10 with the counter at WNT → next PC 0x14. After two BEQ_RESOLVE taken updates for 0x10, the same fetch → next PC 0x18 with PRED_TAKEN_IF_ID = 1.
- STALL held 3 cycles at PC 0x20 → IMEM_ADDR holds 0x20 and IF/ID is unchanged for 3 cycles, then advances to 0x24.
- PCWRITE with REDIRECT_PC = 0x100 together with STALL = 1 → next edge PC = 0x100, INSTR_IF_ID = 0x00000013, VALID_IF_ID = 0, ARS1/ARS2 = 0. The following edge gives PC_IF_ID = 0x100.
- Counter saturation: 4 taken updates leave the counter at ST. An update and lookup on the same index in one cycle → the lookup reflects the old value.
- RST_N pulsed low between clock edges during a redirect → all outputs immediately take their reset values and PC = RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg                                                             |
// | Shared encodings and types for the five-stage core.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_pkg;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [2:0]  F3_BEQ     = 3'b000;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/bht_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bht_predictor                                                        |
// | Table of 2-bit saturating counters: one lookup and one update port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bht_predictor
    import core_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(BHT_ENTRIES)-1:0] i_lookup_idx,
    output logic                           o_predict_taken,
    input  logic                           i_upd_valid,
    input  logic [$clog2(BHT_ENTRIES)-1:0] i_upd_idx,
    input  logic                           i_upd_taken
);

    bht_ctr_t r_ctr [BHT_ENTRIES];
    bht_ctr_t w_ctr_cur;
    bht_ctr_t w_ctr_next;

    assign w_ctr_cur = r_ctr[i_upd_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (i_upd_taken) begin
            if (w_ctr_cur != ST) w_ctr_next = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != SNT) w_ctr_next = w_ctr_cur - 2'b01;
        end
    end

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign o_predict_taken = r_ctr[i_lookup_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_ctr[i] <= WNT;
        end else if (i_upd_valid) begin
            r_ctr[i_upd_idx] <= w_ctr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage                                                          |
// | PC register, BEQ direction prediction and IF/ID pipeline register.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_stage
    import core_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BHT_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_stall,
    input  logic            i_pcwrite,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_beq_resolve,
    input  logic [XLEN-1:0] i_beq_resolve_pc,
    input  logic            i_beq_taken,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [31:0]     i_imem_data,
    output logic [XLEN-1:0] o_pc_if_id,
    output logic [31:0]     o_instr_if_id,
    output logic            o_pred_taken_if_id,
    output logic            o_valid_if_id,
    output logic [4:0]      o_ars1_if_id,
    output logic [4:0]      o_ars2_if_id
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_b_imm;
    logic            w_is_beq;
    logic            w_bht_taken;
    logic            w_pred_taken;
    logic            w_unused_resolve_bits;

    bht_predictor #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_lookup_idx    (r_pc[IDX_W+1:2]),
        .o_predict_taken (w_bht_taken),
        .i_upd_valid     (i_beq_resolve),
        .i_upd_idx       (i_beq_resolve_pc[IDX_W+1:2]),
        .i_upd_taken     (i_beq_taken)
    );

    assign w_unused_resolve_bits = ^{i_beq_resolve_pc[XLEN-1:IDX_W+2], i_beq_resolve_pc[1:0]};

    assign w_is_beq     = (i_imem_data[6:0] == OPC_BRANCH) && (i_imem_data[14:12] == F3_BEQ);
    assign w_pred_taken = w_is_beq && w_bht_taken;

    // B-type immediate {imm[12], imm[11], imm[10:5], imm[4:1], 0}, sign-extended.
    assign w_b_imm = {{(XLEN-13){i_imem_data[31]}}, i_imem_data[31], i_imem_data[7],
                      i_imem_data[30:25], i_imem_data[11:8], 1'b0};

    assign w_next_pc   = w_pred_taken ? (r_pc + w_b_imm) : (r_pc + XLEN'(4));
    assign o_imem_addr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc               <= RESET_PC;
            o_pc_if_id         <= '0;
            o_instr_if_id      <= NOP;
            o_pred_taken_if_id <= 1'b0;
            o_valid_if_id      <= 1'b0;
        end else if (i_pcwrite) begin
            r_pc               <= i_redirect_pc;
            o_pc_if_id         <= '0;
            o_instr_if_id      <= NOP;
            o_pred_taken_if_id <= 1'b0;
            o_valid_if_id      <= 1'b0;
        end else if (!i_stall) begin
            r_pc               <= w_next_pc;
            o_pc_if_id         <= r_pc;
            o_instr_if_id      <= i_imem_data;
            o_pred_taken_if_id <= w_pred_taken;
            o_valid_if_id      <= 1'b1;
        end
    end

    assign o_ars1_if_id = o_instr_if_id[19:15];
    assign o_ars2_if_id = o_instr_if_id[24:20];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_stage                                                       |
// | Directed self-checking bench for fetch_stage.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;
    localparam logic [31:0] c_beq = 32'h0020_8463;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_stall = 1'b0;
    logic        r_pcwrite = 1'b0;
    logic [31:0] r_redirect_pc = '0;
    logic        r_resolve = 1'b0;
    logic [31:0] r_resolve_pc = '0;
    logic        r_taken = 1'b0;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_data;
    logic [31:0] w_pc_if_id;
    logic [31:0] w_instr_if_id;
    logic        w_pred;
    logic        w_valid;
    logic [4:0]  w_ars1;
    logic [4:0]  w_ars2;

    logic [31:0] mem [256];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign w_imem_data = mem[w_imem_addr[9:2]];

    fetch_stage #(
        .XLEN        (32),
        .BHT_ENTRIES (16),
        .RESET_PC    (32'h0)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_stall            (r_stall),
        .i_pcwrite          (r_pcwrite),
        .i_redirect_pc      (r_redirect_pc),
        .i_beq_resolve      (r_resolve),
        .i_beq_resolve_pc   (r_resolve_pc),
        .i_beq_taken        (r_taken),
        .o_imem_addr        (w_imem_addr),
        .i_imem_data        (w_imem_data),
        .o_pc_if_id         (w_pc_if_id),
        .o_instr_if_id      (w_instr_if_id),
        .o_pred_taken_if_id (w_pred),
        .o_valid_if_id      (w_valid),
        .o_ars1_if_id       (w_ars1),
        .o_ars2_if_id       (w_ars2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic taken);
        r_resolve    = 1'b1;
        r_resolve_pc = 32'h10;
        r_taken      = taken;
        step();
        r_resolve    = 1'b0;
    endtask

    // Redirect to the BEQ at 0x10 and look at the prediction it receives.
    task automatic fetch_beq(input string tag, input logic exp_taken);
        r_pcwrite     = 1'b1;
        r_redirect_pc = 32'h10;
        step();
        r_pcwrite     = 1'b0;
        step();
        chk({tag, "_pred"}, 32'(w_pred), 32'(exp_taken));
        chk({tag, "_addr"}, w_imem_addr, exp_taken ? 32'h18 : 32'h14);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_addr"},  w_imem_addr, 32'h0);
        chk({tag, "_instr"}, w_instr_if_id, c_nop);
        chk({tag, "_valid"}, 32'(w_valid), 32'h0);
        chk({tag, "_pc"},    w_pc_if_id, 32'h0);
        chk({tag, "_pred"},  32'(w_pred), 32'h0);
        chk({tag, "_ars"},   {22'h0, w_ars1, w_ars2}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0033 | (32'(i) << 15);
        mem[4] = c_beq;

        #12;
        chk_reset_state("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_addr", w_imem_addr, 32'h0);

        step();
        chk("seq1_addr",  w_imem_addr, 32'h4);
        chk("seq1_pc",    w_pc_if_id, 32'h0);
        chk("seq1_valid", 32'(w_valid), 32'h1);
        chk("seq1_instr", w_instr_if_id, mem[0]);
        step();
        chk("seq2_addr", w_imem_addr, 32'h8);
        chk("seq2_pc",   w_pc_if_id, 32'h4);
        step();
        step();
        chk("seq4_addr", w_imem_addr, 32'h10);

        // BEQ fetched with the counter at WNT falls through.
        step();
        chk("beq_nt_addr",  w_imem_addr, 32'h14);
        chk("beq_nt_instr", w_instr_if_id, c_beq);
        chk("beq_nt_pred",  32'(w_pred), 32'h0);
        chk("beq_nt_pc",    w_pc_if_id, 32'h10);
        chk("beq_ars1",     32'(w_ars1), 32'h1);
        chk("beq_ars2",     32'(w_ars2), 32'h2);

        resolve(1'b1);
        resolve(1'b1);
        r_pcwrite     = 1'b1;
        r_redirect_pc = 32'h10;
        step();
        r_pcwrite = 1'b0;
        chk("redir_addr",  w_imem_addr, 32'h10);
        chk("redir_valid", 32'(w_valid), 32'h0);
        chk("redir_instr", w_instr_if_id, c_nop);
        step();
        chk("beq_t_addr", w_imem_addr, 32'h18);
        chk("beq_t_pred", 32'(w_pred), 32'h1);
        chk("beq_t_pc",   w_pc_if_id, 32'h10);
        step();
        chk("after_t_pc",   w_pc_if_id, 32'h18);
        chk("after_t_pred", 32'(w_pred), 32'h0);
        step();
        chk("pre_stall_addr", w_imem_addr, 32'h20);

        r_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr",  w_imem_addr, 32'h20);
            chk("stall_pc",    w_pc_if_id, 32'h1C);
            chk("stall_instr", w_instr_if_id, mem[7]);
            chk("stall_valid", 32'(w_valid), 32'h1);
        end
        r_stall = 1'b0;
        step();
        chk("unstall_addr",  w_imem_addr, 32'h24);
        chk("unstall_pc",    w_pc_if_id, 32'h20);
        chk("unstall_instr", w_instr_if_id, mem[8]);

        // Redirect wins over a simultaneous stall.
        r_stall       = 1'b1;
        r_pcwrite     = 1'b1;
        r_redirect_pc = 32'h100;
        step();
        r_stall   = 1'b0;
        r_pcwrite = 1'b0;
        chk("ps_addr",  w_imem_addr, 32'h100);
        chk("ps_instr", w_instr_if_id, c_nop);
        chk("ps_valid", 32'(w_valid), 32'h0);
        chk("ps_ars",   {22'h0, w_ars1, w_ars2}, 32'h0);
        chk("ps_pc",    w_pc_if_id, 32'h0);
        step();
        chk("ps2_pc",    w_pc_if_id, 32'h100);
        chk("ps2_addr",  w_imem_addr, 32'h104);
        chk("ps2_instr", w_instr_if_id, mem[64]);
        chk("ps2_valid", 32'(w_valid), 32'h1);

        // ST -> 4 not-taken -> SNT (floor), then climb.
        for (int i = 0; i < 4; i++) resolve(1'b0);
        resolve(1'b1);
        fetch_beq("sat_lo1", 1'b0);
        resolve(1'b1);
        fetch_beq("sat_lo2", 1'b1);
        // WT -> 4 taken -> ST (ceiling), then descend.
        for (int i = 0; i < 4; i++) resolve(1'b1);
        resolve(1'b0);
        fetch_beq("sat_hi1", 1'b1);
        resolve(1'b0);
        fetch_beq("sat_hi2", 1'b0);

        // Counter is WNT; update and lookup collide on the same entry.
        r_pcwrite     = 1'b1;
        r_redirect_pc = 32'h10;
        step();
        r_pcwrite    = 1'b0;
        r_resolve    = 1'b1;
        r_resolve_pc = 32'h10;
        r_taken      = 1'b1;
        step();
        r_resolve = 1'b0;
        chk("same_pred", 32'(w_pred), 32'h0);
        chk("same_addr", w_imem_addr, 32'h14);
        fetch_beq("same_after", 1'b1);

        // Asynchronous reset between edges while a redirect is pending.
        r_pcwrite     = 1'b1;
        r_redirect_pc = 32'h200;
        step();
        chk("ar_pre_addr", w_imem_addr, 32'h200);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("arst");
        r_pcwrite = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("ar_rel_addr",  w_imem_addr, 32'h4);
        chk("ar_rel_valid", 32'(w_valid), 32'h1);
        chk("ar_rel_pc",    w_pc_if_id, 32'h0);
        fetch_beq("bht_rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
